// File: rtl/reg_file_pkg.sv
// Shared types and constants for the multi-port register file.
package reg_file_pkg;

  typedef enum logic {RF_CLEAR, RF_READY} rf_state_e;

  localparam int unsigned RF_ZERO_ADDR = 0;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write tracker: one bit per register, set on issue, cleared by writeback, looked up per
// read port with the same latency as the read data.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned FILE_DEPTH = 32,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 1,
  parameter int unsigned REG_OUTPUT = 0,
  parameter int unsigned ADDR_WIDTH = $clog2(FILE_DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clearing,
  input  logic                         issue_en,
  input  logic [ADDR_WIDTH-1:0]        issue_addr,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  output logic [NUM_RD-1:0]            rd_pending
);

  logic [FILE_DEPTH-1:0] pend_q, pend_d;
  logic [NUM_RD-1:0]     look;

  // Issue is applied after writeback clears so a same-cycle set wins.
  always_comb begin
    pend_d = pend_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w]) pend_d[wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
    end
    if (issue_en && issue_addr != ADDR_WIDTH'(RF_ZERO_ADDR)) pend_d[issue_addr] = 1'b1;
    if (clearing) pend_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  always_comb begin
    look = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      logic [ADDR_WIDTH-1:0] ra;
      logic                  hit;
      ra  = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      hit = 1'b0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == ra) hit = 1'b1;
      end
      look[p] = pend_q[ra] & ~hit & ~clearing;
    end
  end

  if (REG_OUTPUT != 0) begin : g_reg
    logic [NUM_RD-1:0] look_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) look_q <= '0;
      else       look_q <= look;
    end
    assign rd_pending = clearing ? '0 : look_q;
  end else begin : g_comb
    assign rd_pending = look;
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port RV32 integer register file with write-to-read bypass and a zeroing sweep after reset.
// Define REG_FILE_SCOREBOARD_EN to add issue tracking ports (i_issue_en, i_issue_addr, o_rd_pending).
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter  int unsigned REG_WIDTH  = 32,
  parameter  int unsigned FILE_DEPTH = 32,
  parameter  int unsigned NUM_RD     = 2,
  parameter  int unsigned NUM_WR     = 1,
  parameter  int unsigned REG_OUTPUT = 0,
  localparam int unsigned ADDR_WIDTH = $clog2(FILE_DEPTH)
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_clear,
  output logic                         o_ready,
`ifdef REG_FILE_SCOREBOARD_EN
  input  logic                         i_issue_en,
  input  logic [ADDR_WIDTH-1:0]        i_issue_addr,
  output logic [NUM_RD-1:0]            o_rd_pending,
`endif
  input  logic [NUM_RD*ADDR_WIDTH-1:0] i_rd_addr,
  output logic [NUM_RD*REG_WIDTH-1:0]  o_rd_data,
  input  logic [NUM_WR-1:0]            i_wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [NUM_WR*REG_WIDTH-1:0]  i_wr_data
);

  rf_state_e             state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  ready_q;
  logic [REG_WIDTH-1:0]  regs_q [FILE_DEPTH];
  logic                  clearing;
  logic [NUM_WR-1:0]     wr_act;

  assign clearing = (state_q == RF_CLEAR);
  assign wr_act   = clearing ? '0 : i_wr_en;
  assign o_ready  = ready_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        RF_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == ADDR_WIDTH'(FILE_DEPTH - 1)) begin
            state_q <= RF_READY;
            ready_q <= 1'b1;
          end
        end
        RF_READY: begin
          if (i_clear) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // Storage has no reset; the sweep zeroes it. Later write ports override earlier ones.
  always_ff @(posedge i_clk) begin
    if (clearing) begin
      regs_q[cnt_q] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (i_wr_en[w] && i_wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(RF_ZERO_ADDR)) begin
          regs_q[i_wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= i_wr_data[w*REG_WIDTH +: REG_WIDTH];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [REG_WIDTH-1:0]  val;

    assign ra = i_rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      val = regs_q[ra];
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_act[w] && i_wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == ra) begin
          val = i_wr_data[w*REG_WIDTH +: REG_WIDTH];
        end
      end
      if (clearing || ra == ADDR_WIDTH'(RF_ZERO_ADDR)) val = '0;
    end

    if (REG_OUTPUT != 0) begin : g_reg
      logic [REG_WIDTH-1:0] val_q;
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) val_q <= '0;
        else         val_q <= val;
      end
      assign o_rd_data[p*REG_WIDTH +: REG_WIDTH] = clearing ? '0 : val_q;
    end else begin : g_comb
      assign o_rd_data[p*REG_WIDTH +: REG_WIDTH] = val;
    end
  end

`ifdef REG_FILE_SCOREBOARD_EN
  reg_file_scoreboard #(
    .FILE_DEPTH (FILE_DEPTH),
    .NUM_RD     (NUM_RD),
    .NUM_WR     (NUM_WR),
    .REG_OUTPUT (REG_OUTPUT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk        (i_clk),
    .reset      (i_reset),
    .clearing   (clearing),
    .issue_en   (i_issue_en),
    .issue_addr (i_issue_addr),
    .rd_addr    (i_rd_addr),
    .wr_en      (wr_act),
    .wr_addr    (i_wr_addr),
    .rd_pending (o_rd_pending)
  );
`endif

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench: a combinational-read and a registered-read instance share stimulus; the
// stimulus queues expected values tagged with the cycle they must appear in, a monitor checks them.
module tb_reg_file_mp;

  logic        clk;
  logic        i_reset, i_clear;
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        ready_c, ready_r;
  logic [63:0] rd_c, rd_r;
`ifdef REG_FILE_SCOREBOARD_EN
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic [1:0]  pend_c, pend_r;
`endif

  typedef struct {
    int          cyc;
    int          kind;
    int          port;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  reg_file_mp #(.NUM_RD(2), .NUM_WR(2), .REG_OUTPUT(0)) u_dut_c (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_clear      (i_clear),
    .o_ready      (ready_c),
`ifdef REG_FILE_SCOREBOARD_EN
    .i_issue_en   (issue_en),
    .i_issue_addr (issue_addr),
    .o_rd_pending (pend_c),
`endif
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_c),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data)
  );

  reg_file_mp #(.NUM_RD(2), .NUM_WR(2), .REG_OUTPUT(1)) u_dut_r (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_clear      (i_clear),
    .o_ready      (ready_r),
`ifdef REG_FILE_SCOREBOARD_EN
    .i_issue_en   (issue_en),
    .i_issue_addr (issue_addr),
    .o_rd_pending (pend_r),
`endif
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_r),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(int k, int p);
    case (k)
      0: return rd_c[p*32 +: 32];
      1: return rd_r[p*32 +: 32];
      2: return {31'b0, ready_c};
      3: return {31'b0, ready_r};
`ifdef REG_FILE_SCOREBOARD_EN
      4: return {31'b0, pend_c[p]};
      5: return {31'b0, pend_r[p]};
`endif
      default: return 'x;
    endcase
  endfunction

  // Monitor: every expectation due this cycle is compared; overdue ones count as failures.
  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        act = actual(q[i].kind, q[i].port);
        checks++;
        if (q[i].cyc != cyc || act !== q[i].exp) begin
          errors++;
          $display("FAIL %s (kind %0d port %0d cyc %0d): got %h, expected %h", q[i].name,
                   q[i].kind, q[i].port, q[i].cyc, act, q[i].exp);
        end
        q.delete(i);
      end
    end
  end

  task automatic push(int c, int k, int p, logic [31:0] e, string n);
    exp_t item;
    item = '{c, k, p, e, n};
    q.push_back(item);
  endtask

  // Combinational instance now, registered instance one cycle later.
  task automatic exp_rd(int p, logic [31:0] e, string n);
    push(cyc, 0, p, e, n);
    push(cyc + 1, 1, p, e, n);
  endtask

  task automatic exp_rdy(logic e, string n);
    push(cyc, 2, 0, {31'b0, e}, n);
    push(cyc, 3, 0, {31'b0, e}, n);
  endtask

`ifdef REG_FILE_SCOREBOARD_EN
  task automatic exp_pd(int p, logic e, string n);
    push(cyc, 4, p, {31'b0, e}, n);
    push(cyc + 1, 5, p, {31'b0, e}, n);
  endtask
`endif

  task automatic rd(int a0, int a1);
    rd_addr = {5'(a1), 5'(a0)};
  endtask

  task automatic wr(int p, int a, logic [31:0] d);
    wr_en[p]            = 1'b1;
    wr_addr[p*5 +: 5]   = 5'(a);
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    wr_en   = '0;
    i_clear = 1'b0;
`ifdef REG_FILE_SCOREBOARD_EN
    issue_en = 1'b0;
`endif
  endtask

  initial begin
    i_reset = 1'b1;
    i_clear = 1'b0;
    rd_addr = '0;
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
`ifdef REG_FILE_SCOREBOARD_EN
    issue_en   = 1'b0;
    issue_addr = '0;
`endif
    step();
    step();

    // Reset state, then the 32-cycle sweep.
    rd(5, 6);
    exp_rdy(1'b0, "reset_ready");
    push(cyc, 1, 0, 32'h0, "reset_rd_reg");
    i_reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      exp_rdy(1'b0, "sweep_ready_low");
      step();
    end
    exp_rdy(1'b1, "sweep_ready_high");
    checks++;
    if (ready_c !== 1'b1) begin
      errors++;
      $display("FAIL direct sweep ready_c: got %b", ready_c);
    end
    checks++;
    if (ready_r !== 1'b1) begin
      errors++;
      $display("FAIL direct sweep ready_r: got %b", ready_r);
    end
    for (int i = 0; i < 16; i++) begin
      rd(2 * i, 2 * i + 1);
      exp_rd(0, 32'h0, "init_zero_p0");
      exp_rd(1, 32'h0, "init_zero_p1");
      step();
    end

    // Bypass and stored read.
    wr(0, 5, 32'hDEAD_BEEF);
    rd(5, 0);
    exp_rd(0, 32'hDEAD_BEEF, "bypass_x5");
    exp_rd(1, 32'h0, "read_x0");
    #1;
    checks++;
    if (rd_c[31:0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL direct bypass_x5: got %h", rd_c[31:0]);
    end
    step();
    rd(6, 5);
    exp_rd(0, 32'h0, "read_x6");
    exp_rd(1, 32'hDEAD_BEEF, "stored_x5");
    #1;
    checks++;
    if (rd_r[31:0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL direct registered bypass_x5: got %h", rd_r[31:0]);
    end
    step();

    // Write-port priority and hardwired x0.
    wr(0, 7, 32'h11);
    wr(1, 7, 32'h22);
    rd(7, 5);
    exp_rd(0, 32'h22, "prio_bypass_x7");
    exp_rd(1, 32'hDEAD_BEEF, "keep_x5");
    #1;
    checks++;
    if (rd_c[31:0] !== 32'h22) begin
      errors++;
      $display("FAIL direct prio_bypass_x7: got %h", rd_c[31:0]);
    end
    step();
    wr(0, 0, 32'hFFFF);
    rd(7, 0);
    exp_rd(0, 32'h22, "prio_stored_x7");
    exp_rd(1, 32'h0, "x0_no_bypass");
    step();
    rd(0, 7);
    exp_rd(0, 32'h0, "x0_stored");
    exp_rd(1, 32'h22, "x7_again");
    #1;
    checks++;
    if (rd_c[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL direct x0_stored: got %h", rd_c[31:0]);
    end
    step();

    // Load x1..x31, then clear.
    for (int i = 1; i < 32; i++) begin
      wr(0, i, 32'hA500_0000 | i);
      rd(i, i - 1);
      exp_rd(0, 32'hA500_0000 | i, "load_bypass");
      exp_rd(1, (i == 1) ? 32'h0 : (32'hA500_0000 | (i - 1)), "load_stored");
      step();
    end
    i_clear = 1'b1;
    rd(31, 1);
    push(cyc, 0, 0, 32'hA500_001F, "pre_clear_x31");
    push(cyc, 0, 1, 32'hA500_0001, "pre_clear_x1");
    push(cyc + 1, 1, 0, 32'h0, "clear_rd_reg_forced");
    exp_rdy(1'b1, "clear_cycle_ready");
    step();
    for (int i = 0; i < 32; i++) begin
      exp_rdy(1'b0, "clear_ready_low");
      rd(31, 1);
      exp_rd(0, 32'h0, "clear_rd_forced_p0");
      exp_rd(1, 32'h0, "clear_rd_forced_p1");
      if (i == 20) wr(0, 2, 32'hBAD0_0002);
      step();
    end
    exp_rdy(1'b1, "clear_ready_high");
    for (int i = 0; i < 16; i++) begin
      rd(2 * i, 2 * i + 1);
      exp_rd(0, 32'h0, "cleared_p0");
      exp_rd(1, 32'h0, "cleared_p1");
      step();
    end

    // Reset at sweep cycle 10 restarts the sweep.
    i_clear = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      exp_rdy(1'b0, "resweep_low");
      step();
    end
    i_reset = 1'b1;
    exp_rdy(1'b0, "mid_reset_ready");
    step();
    i_reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      exp_rdy(1'b0, "restart_low");
      step();
    end
    exp_rdy(1'b1, "restart_high");
    checks++;
    if (ready_c !== 1'b1) begin
      errors++;
      $display("FAIL direct restart_high: got %b", ready_c);
    end
    step();

`ifdef REG_FILE_SCOREBOARD_EN
    issue_en   = 1'b1;
    issue_addr = 5'd3;
    rd(3, 4);
    exp_pd(0, 1'b0, "pend_before_set");
    step();
    rd(3, 4);
    exp_pd(0, 1'b1, "pend_set_x3");
    exp_pd(1, 1'b0, "pend_x4_idle");
    step();
    issue_en   = 1'b1;
    issue_addr = 5'd3;
    wr(0, 3, 32'h33);
    rd(3, 4);
    exp_pd(0, 1'b0, "pend_masked_by_write");
    step();
    rd(3, 4);
    exp_pd(0, 1'b1, "pend_set_wins");
    step();
    wr(1, 3, 32'h44);
    rd(3, 4);
    exp_pd(0, 1'b0, "pend_write_masks");
    step();
    rd(3, 4);
    exp_pd(0, 1'b0, "pend_cleared");
    step();
`endif

    step();
    step();
    foreach (q[i]) begin
      checks++;
      errors++;
      $display("FAIL %s never checked (cyc %0d), expected %h", q[i].name, q[i].cyc, q[i].exp);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
